// File: rtl/cmd_pkt_assembler_if.sv
// Byte-in / packet-out bus between the UART receiver, the command assembler
// and the command-configuration consumer.
//   rx_rdy/rx_data   : UART byte available (level) and the byte itself
//   clr_rx_rdy       : assembler acknowledges the byte (combinational)
//   clr_cmd_rdy      : consumer acknowledges the current packet
//   cmd_rdy/cmd/data : last complete packet, cmd_rdy held until acknowledged
//   pkt_err          : one-cycle pulse when a partial packet times out
// master = stimulus/consumer side, slave = assembler side.
interface cmd_pkt_assembler_if;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned DATA_W = 16;

   logic              rx_rdy;
   logic [BYTE_W-1:0] rx_data;
   logic              clr_rx_rdy;
   logic              clr_cmd_rdy;
   logic              cmd_rdy;
   logic [BYTE_W-1:0] cmd;
   logic [DATA_W-1:0] data;
   logic              pkt_err;

   modport master (
      output rx_rdy, rx_data, clr_cmd_rdy,
      input  clr_rx_rdy, cmd_rdy, cmd, data, pkt_err
   );

   modport slave (
      input  rx_rdy, rx_data, clr_cmd_rdy,
      output clr_rx_rdy, cmd_rdy, cmd, data, pkt_err
   );
endinterface

// File: rtl/cmd_pkt_assembler.sv
// Assembles 3-byte command packets (opcode, data[15:8], data[7:0]) from the
// UART byte stream and presents them as cmd/data with a level cmd_rdy.
// A partial packet whose inter-byte gap reaches TIMEOUT_CYC clocks is dropped
// and flagged with a one-cycle pkt_err pulse.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : cmd_pkt_assembler_if.slave (rx byte in, packet out, pkt_err)
module cmd_pkt_assembler #(
   parameter int unsigned TIMEOUT_CYC = 1000000,
   parameter int unsigned TMR_W       = 20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cmd_pkt_assembler_if.slave   bus
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned DATA_W = 16;
   localparam logic [TMR_W-1:0] TMR_LIM = TMR_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_HI = 2'd1,
      WAIT_LO = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [BYTE_W-1:0] hold_cmd_q, hold_cmd_d;
   logic [BYTE_W-1:0] hold_hi_q, hold_hi_d;
   logic [BYTE_W-1:0] cmd_q, cmd_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              cmd_rdy_q, cmd_rdy_d;
   logic              pkt_err_q, pkt_err_d;
   logic              byte_v;
   logic              tmr_at_lim;

   // Every state accepts a byte, so the acknowledge is just rx_rdy outside reset.
   assign byte_v         = bus.rx_rdy & rst_n;
   assign bus.clr_rx_rdy = byte_v;
   assign tmr_at_lim     = (tmr_q == TMR_LIM);

   assign bus.cmd     = cmd_q;
   assign bus.data    = data_q;
   assign bus.cmd_rdy = cmd_rdy_q;
   assign bus.pkt_err = pkt_err_q;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tmr_q      <= '0;
         hold_cmd_q <= '0;
         hold_hi_q  <= '0;
         cmd_q      <= '0;
         data_q     <= '0;
         cmd_rdy_q  <= 1'b0;
         pkt_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         hold_cmd_q <= hold_cmd_d;
         hold_hi_q  <= hold_hi_d;
         cmd_q      <= cmd_d;
         data_q     <= data_d;
         cmd_rdy_q  <= cmd_rdy_d;
         pkt_err_q  <= pkt_err_d;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      hold_cmd_d = hold_cmd_q;
      hold_hi_d  = hold_hi_q;
      cmd_d      = cmd_q;
      data_d     = data_q;
      pkt_err_d  = 1'b0;
      // Acknowledge clears; a completion below overrides it on the same edge.
      cmd_rdy_d  = cmd_rdy_q & ~bus.clr_cmd_rdy;

      unique case (state_q)
         IDLE: begin
            tmr_d = '0;
            if (byte_v) begin
               hold_cmd_d = bus.rx_data;
               cmd_rdy_d  = 1'b0;           // new packet supersedes an unacked one
               state_d    = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (byte_v) begin
               hold_hi_d = bus.rx_data;
               tmr_d     = '0;
               state_d   = WAIT_LO;
            end else if (tmr_at_lim) begin
               tmr_d     = '0;
               pkt_err_d = 1'b1;
               state_d   = IDLE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         WAIT_LO: begin
            if (byte_v) begin
               cmd_d     = hold_cmd_q;
               data_d    = {hold_hi_q, bus.rx_data};
               cmd_rdy_d = 1'b1;
               tmr_d     = '0;
               state_d   = IDLE;
            end else if (tmr_at_lim) begin
               tmr_d     = '0;
               pkt_err_d = 1'b1;
               state_d   = IDLE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         default: begin
            tmr_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: doc/cmd_pkt_assembler.md
Name: cmd_pkt_assembler

Overview:
- Front-end sequencer for the flight-controller command path.
- Consumes bytes from the UART receiver and assembles 3-byte packets: opcode, data[15:8], data[7:0].
- Presents each complete packet as cmd/data with a level cmd_rdy. The command-configuration block consumes it and knocks cmd_rdy down with clr_cmd_rdy.
- Aborts and flags partial packets whose inter-byte gap exceeds a timeout.

Parameters:
TIMEOUT_CYC, 1000000, max idle clocks allowed between bytes of one packet (20 ms at 50 MHz)
TMR_W, 20, width of inter-byte timeout counter; must satisfy 2^TMR_W > TIMEOUT_CYC

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
rx_rdy  in  1  UART byte available; level, held until clr_rx_rdy seen
rx_data  in  8  UART received byte, valid while rx_rdy=1
clr_rx_rdy  out  1  combinational; high in the cycle a byte is captured
clr_cmd_rdy  in  1  consumer acknowledge; clears cmd_rdy
cmd_rdy  out  1  complete packet valid (level)
cmd  out  8  opcode of last complete packet
data  out  16  payload of last complete packet, {byte2, byte3}
pkt_err  out  1  one-cycle pulse when a partial packet is discarded on timeout

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - cmd_rdy=0, cmd=8'h00, data=16'h0000, pkt_err=0.
  - Timer and holding registers are cleared.
  - clr_rx_rdy=0 while in reset.
  - Reset mid-packet discards the partial packet with no pkt_err.
- States:
  - IDLE: waiting for the opcode byte.
  - WAIT_HI: waiting for data[15:8].
  - WAIT_LO: waiting for data[7:0].
- Byte capture:
  - In any state, rx_rdy=1 means clr_rx_rdy=1 combinationally in that cycle, and the byte is captured on that edge.
  - The UART clears rx_rdy on the following edge.
  - Every state is always accepting; no rx_rdy is ever left pending more than one cycle.
- Transitions:
  - IDLE with a byte: opcode goes to hold_cmd, state goes to WAIT_HI, timer cleared. On the same edge cmd_rdy is cleared (a new packet supersedes an unacknowledged one).
  - WAIT_HI with a byte: byte goes to hold_hi, state goes to WAIT_LO, timer cleared.
  - WAIT_LO with a byte: on that edge cmd<=hold_cmd, data<={hold_hi, rx_data}, cmd_rdy<=1, state goes to IDLE.
  - cmd_rdy is visible in the cycle after the third byte's clr_rx_rdy cycle, so latency is 1 clock.
- Output stability: cmd and data change only on packet completion. They stay stable while cmd_rdy=1 and after it is cleared.
- cmd_rdy clear:
  - clr_cmd_rdy=1 at an edge sets cmd_rdy<=0.
  - A completion on the same edge wins, so cmd_rdy<=1.
  - clr_cmd_rdy while cmd_rdy=0 has no effect.
- Timeout:
  - In WAIT_HI or WAIT_LO, the timer increments every cycle with no byte.
  - When the timer equals TIMEOUT_CYC-1 and there is no byte that cycle: state goes to IDLE, pkt_err pulses high for exactly the next cycle, timer is cleared, holding registers are ignored.
  - cmd, data and cmd_rdy are untouched by a timeout.
  - If a byte arrives in the same cycle the timer hits its limit, the byte wins: normal transition, no pkt_err.
  - The timer is held at 0 in IDLE, so there is no timeout between packets.
- Back-to-back: rx_rdy asserted on consecutive cycles is legal. Each cycle captures one byte, so a packet can complete in 3 cycles.
- Widths: the timer saturates logically at the limit compare and never wraps. All payload handling is unsigned byte concatenation with no arithmetic.

Test Plan:
- Basic packet: bytes 0x02, 0x12, 0x34 spaced 10 cycles apart.
  - Required: clr_rx_rdy is a 1-cycle pulse per byte.
  - One cycle after byte 3: cmd=0x02, data=0x1234, cmd_rdy=1.
  - clr_cmd_rdy pulse: cmd_rdy=0 next cycle, cmd and data hold.
- Timeout (TIMEOUT_CYC=16): send 0x05 then 0xAA, then silence.
  - Required: pkt_err pulses exactly once, 16 cycles after 0xAA was captured.
  - Then send 0x01, 0x00, 0x7F: cmd=0x01, data=0x007F, no pkt_err.
- Supersede: complete packet 0x03/0xFF/0xFE, leave it unacknowledged, send opcode 0x04.
  - Required: cmd_rdy=0 after 0x04 is captured, while cmd=0x03 and data=0xFFFE hold.
  - After 0x00, 0x10: cmd=0x04, data=0x0010, cmd_rdy=1.
- Simultaneous: assert clr_cmd_rdy in the same cycle the third byte (0x55) is captured.
  - Required: cmd_rdy=1 afterwards.
  - Byte arriving exactly at the timeout limit: no pkt_err, and the packet continues.
- Reset mid-packet: after bytes 0x06, 0x11, pull rst_n low for 1 edge.
  - Required: state IDLE, all outputs 0, no pkt_err.
  - The next 3 bytes 0x07, 0xAB, 0xCD give cmd=0x07, data=0xABCD.
- Back-to-back: rx_rdy high for 6 consecutive cycles with bytes 0x01..0x06.
  - Required: two packets, cmd=0x01/data=0x0203, then cmd=0x04/data=0x0506.
  - 6 clr_rx_rdy pulses.
